fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of decode/register-file read in the CPU.
- Owns the PC, reads instruction memory, and buffers {pc, instruction} pairs in a small FIFO.
- Hands pairs to decode with a valid/ready handshake.
- Honors start gating and branch/jump redirects with flush.

Parameters:
XLEN, 32, datapath and PC width.
BUF_DEPTH, 2, prefetch FIFO entries (power of two, >=2).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk_i  input  1  clock.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  fetch enable; level-sensitive.
imem_addr_o  output  XLEN  byte address to instruction memory (word index = addr[XLEN-1:2]).
imem_data_i  input  32  instruction word, combinational read of imem_addr_o.
redirect_i  input  1  branch/jump taken; flush and reload PC.
redirect_pc_i  input  XLEN  target PC for redirect.
id_valid_o  output  1  head FIFO entry valid.
id_ready_i  input  1  decode accepts head entry this cycle.
id_instr_o  output  32  head instruction.
id_pc_o  output  XLEN  head PC.
pc_o  output  XLEN  current fetch PC (visible to the bench).

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Reset values:
  - pc_o = RESET_PC.
  - FIFO empty: id_valid_o = 0, id_instr_o = 0, id_pc_o = 0.
  - State = IDLE.
- Reset asserted mid-operation discards all buffered entries and any pending redirect in the same edge.
- States:
  - IDLE: no fetch. Go to RUN on an edge where start_i = 1.
  - RUN: fetch. Return to IDLE on an edge where start_i = 0. Buffered entries remain and keep draining; pc_o holds.
- Memory address: imem_addr_o = pc_o at all times (combinational).
- Fetch (push), in RUN when redirect_i = 0 and the FIFO is not full after this cycle's pop:
  - Push {pc_o, imem_data_i}.
  - pc_o <= pc_o + 4, modulo 2^XLEN; wrap from 0xFFFFFFFC to 0 is silent.
- Pop: when id_valid_o && id_ready_i, the head entry advances at the edge.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full, a push is allowed only if a pop happens in the same cycle.
- Latency: instruction at PC p appears on id_* one cycle after pc_o = p is fetched into an empty FIFO.
- Steady state with id_ready_i = 1: one instruction per cycle.
- Redirect (highest priority after reset):
  - Flush FIFO, so id_valid_o = 0 next cycle.
  - pc_o <= {redirect_pc_i[XLEN-1:2], 2'b00}, misaligned low bits forced to 0.
  - No push that cycle; a pop in the same cycle is ignored (entry flushed).
  - Redirect is honored in IDLE too: PC updates, no fetch.
- Output stability: id_instr_o and id_pc_o are held stable while id_valid_o = 1 and id_ready_i = 0.
- Never push when full without a pop; never pop when empty.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_o, 32 bits: count of pushes.
  - perf_stall_o, 32 bits: count of cycles in RUN with no push and no redirect.
- Both counters reset to 0, saturate at 0xFFFFFFFF, and are not cleared by redirect.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN.
  - INSTR_W = 32.
  - Fetch state enum {FETCH_IDLE, FETCH_RUN}.
  - PC_STEP = 4.
  - NOP encoding 32'h00000013 (bench use).
- One sub-module, fetch_buffer:
  - Parameterised synchronous FIFO with push/pop/flush.
  - Outputs full/empty/head.
  - Pointer width = log2(BUF_DEPTH) + 1.

Test Plan:
- Memory words 0..3 = A, B, C, D; reset, start_i = 1, id_ready_i = 1 -> id_pc_o sequence 0, 4, 8, 12 on consecutive cycles after 1-cycle latency, id_instr_o = A, B, C, D.
- id_ready_i = 0 for 5 cycles after start -> FIFO fills with PCs 0 and 4 and pc_o stops at 8. Head holds PC 0. On release, pops give 0, 4, 8 with no bubble.
- Redirect with redirect_pc_i = 0x40 while FIFO is full -> next cycle id_valid_o = 0, pc_o = 0x40; the cycle after, id_pc_o = 0x40.
- redirect_pc_i = 0x43 -> pc_o = 0x40. Separately, set pc near the top of the address range -> pc_o goes 0xFFFFFFFC then 0x00000000.
- start_i dropped mid-stream -> pc_o freezes and buffered entries drain. Assert rst_i mid-stream -> next cycle pc_o = 0, id_valid_o = 0, state IDLE.
- FETCH_PERF_EN defined, 10 RUN cycles with 3 backpressure stalls -> perf_fetch_o = 7, perf_stall_o = 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch state encoding and small helpers.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Event counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding {pc, instruction} pairs between fetch and decode.
// Flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // The extra pointer bit distinguishes a full buffer from an empty one.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign head_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible once the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem and queues {pc, instr} for decode.
// Optional FETCH_PERF_EN adds saturating fetch and stall event counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic [INSTR_W-1:0]  imem_data_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [INSTR_W-1:0]  id_instr_o,
  output logic [XLEN-1:0]     id_pc_o,
  output logic [XLEN-1:0]     pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_o,
  output logic [31:0]         perf_stall_o
`endif
);

  localparam int ENTRY_W = XLEN + INSTR_W;

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [XLEN-1:0]      pc;
  logic [ENTRY_W-1:0]   head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 do_push;
  logic                 do_pop;
  logic                 unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect flushes the buffer, so a same-cycle handshake never consumes an entry.
  always_comb begin
    state_nxt = state;
    do_pop    = 1'b0;
    do_push   = 1'b0;
    case (state)
      FETCH_IDLE: if (start_i)  state_nxt = FETCH_RUN;
      FETCH_RUN:  if (!start_i) state_nxt = FETCH_IDLE;
      default:    state_nxt = FETCH_IDLE;
    endcase
    do_pop  = !fifo_empty && id_ready_i && !redirect_i;
    do_push = (state == FETCH_RUN) && !redirect_i && (!fifo_full || do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (do_push) begin
      pc <= pc + XLEN'(PC_STEP);
    end
  end

  fetch_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .flush_i (redirect_i),
    .data_i  ({pc, imem_data_i}),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign id_valid_o  = !fifo_empty;
  assign id_pc_o     = fifo_empty ? '0 : head[ENTRY_W-1 -: XLEN];
  assign id_instr_o  = fifo_empty ? '0 : head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  // Stall means the stage was running but could not fetch; redirect cycles are excluded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (do_push) begin
        perf_fetch <= sat_inc32(perf_fetch);
      end
      if ((state == FETCH_RUN) && !do_push && !redirect_i) begin
        perf_stall <= sat_inc32(perf_stall);
      end
    end
  end

  assign perf_fetch_o = perf_fetch;
  assign perf_stall_o = perf_stall;
`endif

endmodule
